// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the shared datapath/memory port.
// master = the controller; slave = the datapath side that supplies op/Zero/mem_ready.
interface multicycle_controller_if #(
    parameter int CNT_WIDTH = 32
);
    logic [6:0]           op;
    logic                 Zero;
    logic                 mem_ready;
    logic                 mem_req;
    logic                 PCWrite;
    logic                 AdrSrc;
    logic                 MemWrite;
    logic                 IRWrite;
    logic [1:0]           ResultSrc;
    logic [1:0]           ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [1:0]           ALUOp;
    logic                 RegWrite;
    logic [1:0]           ImmSrc;
    logic [3:0]           state;
    logic [CNT_WIDTH-1:0] instr_count;
    logic                 illegal;

    modport master (
        input  op, Zero, mem_ready,
        output mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUOp, RegWrite, ImmSrc, state, instr_count, illegal
    );

    modport slave (
        output op, Zero, mem_ready,
        input  mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUOp, RegWrite, ImmSrc, state, instr_count, illegal
    );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32 subset core: sequences the shared memory port,
// ALU and register file, counts retired instructions and flags unsupported opcodes.
module multicycle_controller #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_controller_if.master bus
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_JAL      = 4'd8;
    localparam logic [3:0] S_ALUWB    = 4'd9;
    localparam logic [3:0] S_BEQ      = 4'd10;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic [3:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 illegal_q, illegal_d;

    logic       retire, pc_update, branch;
    logic       mem_req_s, ir_write_s, mem_write_s, reg_write_s, adr_src_s;
    logic [1:0] result_src_s, alu_src_a_s, alu_src_b_s, alu_op_s;

    // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d      = state_q;
        illegal_d    = illegal_q;
        retire       = 1'b0;
        pc_update    = 1'b0;
        branch       = 1'b0;
        mem_req_s    = 1'b0;
        ir_write_s   = 1'b0;
        mem_write_s  = 1'b0;
        reg_write_s  = 1'b0;
        adr_src_s    = 1'b0;
        result_src_s = 2'b00;
        alu_src_a_s  = 2'b00;
        alu_src_b_s  = 2'b00;
        alu_op_s     = 2'b00;

        case (state_q)
            S_FETCH: begin
                mem_req_s    = 1'b1;
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                ir_write_s   = bus.mem_ready;
                pc_update    = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Branch target PC_old + imm lands in ALUOut for a following BEQ.
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b01;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                state_d     = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req_s = 1'b1;
                adr_src_s = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
                retire       = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_s   = 1'b1;
                adr_src_s   = 1'b1;
                mem_write_s = 1'b1;
                if (bus.mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXECUTER: begin
                alu_src_a_s = 2'b10;
                alu_op_s    = 2'b10;
                state_d     = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
                alu_op_s    = 2'b10;
                state_d     = S_ALUWB;
            end
            S_JAL: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b10;
                pc_update   = 1'b1;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a_s = 2'b10;
                alu_op_s    = 2'b01;
                branch      = 1'b1;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        count_d = retire ? count_q + CNT_WIDTH'(1) : count_q;
    end

    always_comb begin
        case (bus.op)
            OP_SW:   bus.ImmSrc = 2'b01;
            OP_BEQ:  bus.ImmSrc = 2'b10;
            OP_JAL:  bus.ImmSrc = 2'b11;
            default: bus.ImmSrc = 2'b00;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            count_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
        end
    end

    // Write enables and the memory request are gated by rst_n so they drop the instant reset asserts.
    assign bus.mem_req     = rst_n & mem_req_s;
    assign bus.PCWrite     = rst_n & (pc_update | (branch & bus.Zero));
    assign bus.IRWrite     = rst_n & ir_write_s;
    assign bus.MemWrite    = rst_n & mem_write_s;
    assign bus.RegWrite    = rst_n & reg_write_s;
    assign bus.AdrSrc      = adr_src_s;
    assign bus.ResultSrc   = result_src_s;
    assign bus.ALUSrcA     = alu_src_a_s;
    assign bus.ALUSrcB     = alu_src_b_s;
    assign bus.ALUOp       = alu_op_s;
    assign bus.state       = state_q;
    assign bus.instr_count = count_q;
    assign bus.illegal     = illegal_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: stimulus queues the hand-computed per-cycle
// response, a negedge monitor pops and compares against what the DUT presents.
module tb_multicycle_controller;
    localparam int CW = 3;  // narrow counter so a handful of instructions reaches the wrap

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
                           MEMWB = 4'd4, MEMWRITE = 4'd5, EXECR = 4'd6, EXECI = 4'd7,
                           JAL = 4'd8, ALUWB = 4'd9, BEQ = 4'd10;

    // {mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, RegWrite, ImmSrc}
    localparam logic [15:0] E_FETCH_R  = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 2'b00};
    localparam logic [15:0] E_FETCH_W  = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 2'b00};
    localparam logic [15:0] E_DECODE   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 2'b00};
    localparam logic [15:0] E_MEMADR   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 2'b00};
    localparam logic [15:0] E_MEMREAD  = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00};
    localparam logic [15:0] E_MEMWB    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00};
    localparam logic [15:0] E_MEMWRITE = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00};
    localparam logic [15:0] E_EXECR    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 2'b00};
    localparam logic [15:0] E_EXECI    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0, 2'b00};
    localparam logic [15:0] E_JAL      = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 2'b00};
    localparam logic [15:0] E_ALUWB    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00};
    localparam logic [15:0] E_BEQ_T    = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0, 2'b00};
    localparam logic [15:0] E_BEQ_N    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0, 2'b00};

    typedef struct packed {
        logic [3:0]    st;
        logic [15:0]   ctl;
        logic [CW-1:0] cnt;
        logic          ill;
    } exp_t;

    typedef struct {
        exp_t  e;
        string tag;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_controller_if #(.CNT_WIDTH(CW)) bus ();
    multicycle_controller #(.CNT_WIDTH(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [15:0] act_ctl;
    assign act_ctl = {bus.mem_req, bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
                      bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.RegWrite, bus.ImmSrc};

    rec_t          sb[$];
    int            applied = 0;
    int            miscompares = 0;
    logic [CW-1:0] exp_cnt;
    logic          exp_ill;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] req);
        applied++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, act, req);
        end
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle.
    always @(negedge clk) begin
        rec_t r;
        if (rst_n === 1'b1 && sb.size() > 0) begin
            r = sb.pop_front();
            check(r.tag, 64'({bus.state, act_ctl, bus.instr_count, bus.illegal}), 64'(r.e));
        end
    end

    task automatic step(input string tag, input logic [6:0] op, input logic z, input logic rdy,
                        input logic [3:0] st, input logic [15:0] ctl, input logic [1:0] imm,
                        input logic ret, input logic set_ill);
        rec_t r;
        bus.op        = op;
        bus.Zero      = z;
        bus.mem_ready = rdy;
        r.e.st  = st;
        r.e.ctl = ctl | {14'b0, imm};
        r.e.cnt = exp_cnt;
        r.e.ill = exp_ill;
        r.tag   = tag;
        sb.push_back(r);
        @(posedge clk);
        #1;
        if (ret) exp_cnt = exp_cnt + 1'b1;
        if (set_ill) exp_ill = 1'b1;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_state"}, 64'(bus.state), 64'(FETCH));
        check({tag, "_enables"}, 64'({bus.mem_req, bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite}), 64'(0));
        check({tag, "_count"}, 64'(bus.instr_count), 64'(0));
        check({tag, "_illegal"}, 64'(bus.illegal), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        bus.op        = OP_LW;
        bus.Zero      = 1'b0;
        bus.mem_ready = 1'b1;
        exp_cnt       = '0;
        exp_ill       = 1'b0;
        #2;
        reset_checks("por");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // lw, no wait states: 5 cycles
        step("lw_fetch",   OP_LW, 0, 1, FETCH,   E_FETCH_R, 2'b00, 0, 0);
        step("lw_decode",  OP_LW, 0, 1, DECODE,  E_DECODE,  2'b00, 0, 0);
        step("lw_memadr",  OP_LW, 0, 1, MEMADR,  E_MEMADR,  2'b00, 0, 0);
        step("lw_memread", OP_LW, 0, 1, MEMREAD, E_MEMREAD, 2'b00, 0, 0);
        step("lw_memwb",   OP_LW, 0, 1, MEMWB,   E_MEMWB,   2'b00, 1, 0);

        // lw with three wait cycles in MEMREAD: 8 cycles
        step("lw2_fetch",   OP_LW, 0, 1, FETCH,   E_FETCH_R, 2'b00, 0, 0);
        step("lw2_decode",  OP_LW, 0, 1, DECODE,  E_DECODE,  2'b00, 0, 0);
        step("lw2_memadr",  OP_LW, 0, 1, MEMADR,  E_MEMADR,  2'b00, 0, 0);
        for (int i = 0; i < 3; i++)
            step("lw2_memread_wait", OP_LW, 0, 0, MEMREAD, E_MEMREAD, 2'b00, 0, 0);
        step("lw2_memread", OP_LW, 0, 1, MEMREAD, E_MEMREAD, 2'b00, 0, 0);
        step("lw2_memwb",   OP_LW, 0, 1, MEMWB,   E_MEMWB,   2'b00, 1, 0);

        // sw: 4 cycles, ImmSrc=01, single MemWrite cycle
        step("sw_fetch",    OP_SW, 0, 1, FETCH,    E_FETCH_R,  2'b01, 0, 0);
        step("sw_decode",   OP_SW, 0, 1, DECODE,   E_DECODE,   2'b01, 0, 0);
        step("sw_memadr",   OP_SW, 0, 1, MEMADR,   E_MEMADR,   2'b01, 0, 0);
        step("sw_memwrite", OP_SW, 0, 1, MEMWRITE, E_MEMWRITE, 2'b01, 1, 0);

        // beq taken then not taken
        step("beqt_fetch",  OP_BEQ, 1, 1, FETCH,  E_FETCH_R, 2'b10, 0, 0);
        step("beqt_decode", OP_BEQ, 1, 1, DECODE, E_DECODE,  2'b10, 0, 0);
        step("beqt_beq",    OP_BEQ, 1, 1, BEQ,    E_BEQ_T,   2'b10, 1, 0);
        step("beqn_fetch",  OP_BEQ, 0, 1, FETCH,  E_FETCH_R, 2'b10, 0, 0);
        step("beqn_decode", OP_BEQ, 0, 1, DECODE, E_DECODE,  2'b10, 0, 0);
        step("beqn_beq",    OP_BEQ, 0, 1, BEQ,    E_BEQ_N,   2'b10, 1, 0);

        // illegal opcode: back to FETCH, sticky flag, no retire
        step("ill_fetch",  OP_BAD, 0, 1, FETCH,  E_FETCH_R, 2'b00, 0, 0);
        step("ill_decode", OP_BAD, 0, 1, DECODE, E_DECODE,  2'b00, 0, 1);

        // R-type with one fetch wait cycle
        step("r_fetch_wait", OP_R, 0, 0, FETCH, E_FETCH_W, 2'b00, 0, 0);
        step("r_fetch",      OP_R, 0, 1, FETCH, E_FETCH_R, 2'b00, 0, 0);
        step("r_decode",     OP_R, 0, 1, DECODE, E_DECODE, 2'b00, 0, 0);
        step("r_exec",       OP_R, 0, 1, EXECR,  E_EXECR,  2'b00, 0, 0);
        step("r_aluwb",      OP_R, 0, 1, ALUWB,  E_ALUWB,  2'b00, 1, 0);

        // I-ALU brings the 3-bit count to all-ones, jal wraps it to 0
        step("i_fetch",  OP_I, 0, 1, FETCH,  E_FETCH_R, 2'b00, 0, 0);
        step("i_decode", OP_I, 0, 1, DECODE, E_DECODE,  2'b00, 0, 0);
        step("i_exec",   OP_I, 0, 1, EXECI,  E_EXECI,   2'b00, 0, 0);
        step("i_aluwb",  OP_I, 0, 1, ALUWB,  E_ALUWB,   2'b00, 1, 0);
        step("jal_fetch",  OP_JAL, 0, 1, FETCH,  E_FETCH_R, 2'b11, 0, 0);
        step("jal_decode", OP_JAL, 0, 1, DECODE, E_DECODE,  2'b11, 0, 0);
        step("jal_jal",    OP_JAL, 0, 1, JAL,    E_JAL,     2'b11, 0, 0);
        step("jal_aluwb",  OP_JAL, 0, 1, ALUWB,  E_ALUWB,   2'b11, 1, 0);

        // sw with one wait cycle in MEMWRITE
        step("sw2_fetch",    OP_SW, 0, 1, FETCH,    E_FETCH_R,  2'b01, 0, 0);
        step("sw2_decode",   OP_SW, 0, 1, DECODE,   E_DECODE,   2'b01, 0, 0);
        step("sw2_memadr",   OP_SW, 0, 1, MEMADR,   E_MEMADR,   2'b01, 0, 0);
        step("sw2_mw_wait",  OP_SW, 0, 0, MEMWRITE, E_MEMWRITE, 2'b01, 0, 0);
        step("sw2_memwrite", OP_SW, 0, 1, MEMWRITE, E_MEMWRITE, 2'b01, 1, 0);
        step("post_wrap_fetch", OP_LW, 0, 1, FETCH, E_FETCH_R, 2'b00, 0, 0);

        // lw interrupted by reset while waiting in MEMREAD
        step("lw3_decode",  OP_LW, 0, 1, DECODE,  E_DECODE,  2'b00, 0, 0);
        step("lw3_memadr",  OP_LW, 0, 1, MEMADR,  E_MEMADR,  2'b00, 0, 0);
        step("lw3_memread", OP_LW, 0, 0, MEMREAD, E_MEMREAD, 2'b00, 0, 0);
        #1;
        rst_n = 1'b0;
        #1;
        reset_checks("midrst");
        exp_cnt = '0;
        exp_ill = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        step("lw4_fetch",   OP_LW, 0, 1, FETCH,   E_FETCH_R, 2'b00, 0, 0);
        step("lw4_decode",  OP_LW, 0, 1, DECODE,  E_DECODE,  2'b00, 0, 0);
        step("lw4_memadr",  OP_LW, 0, 1, MEMADR,  E_MEMADR,  2'b00, 0, 0);
        step("lw4_memread", OP_LW, 0, 1, MEMREAD, E_MEMREAD, 2'b00, 0, 0);
        step("lw4_memwb",   OP_LW, 0, 1, MEMWB,   E_MEMWB,   2'b00, 1, 0);
        step("final_fetch", OP_LW, 0, 1, FETCH,   E_FETCH_R, 2'b00, 0, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            applied++;
            miscompares++;
            $display("FAIL drain: %0d expected records left unchecked, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Main control FSM for the multicycle RV32 subset core (lw, sw, R-type, I-type ALU, beq, jal). It sequences the shared datapath across cycles: the single memory port, the ALU, the register file, and the Sign_Extend unit via ImmSrc. It drives all mux selects and write enables, and handshakes with memory through mem_req/mem_ready. It also keeps a retired-instruction counter and a sticky illegal-opcode flag. Sits between the instruction register and the datapath; the ALU decoder consumes ALUOp separately.

Parameters:
CNT_WIDTH, 32, width of instr_count.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
op  input  7  opcode field Instr[6:0] from the instruction register.
Zero  input  1  ALU zero flag.
mem_ready  input  1  memory completes the current access this cycle.
mem_req  output  1  memory access request.
PCWrite  output  1  PC register enable.
AdrSrc  output  1  memory address select: 0=PC, 1=Result.
MemWrite  output  1  memory write enable.
IRWrite  output  1  instruction register / OldPC enable.
ResultSrc  output  2  result select: 00=ALUOut, 01=Data, 10=ALUResult.
ALUSrcA  output  2  ALU A select: 00=PC, 01=OldPC, 10=RD1.
ALUSrcB  output  2  ALU B select: 00=RD2, 01=ImmExt, 10=const 4.
ALUOp  output  2  00=add, 01=sub, 10=decode funct fields.
RegWrite  output  1  register file write enable.
ImmSrc  output  2  Sign_Extend format: 00=I, 01=S, 10=B, 11=J.
state  output  4  current state encoding (debug).
instr_count  output  CNT_WIDTH  retired-instruction count.
illegal  output  1  sticky flag set on an unsupported opcode.

Behaviour:
- rst_n low (asynchronous): state=FETCH, instr_count=0, illegal=0. PCWrite, IRWrite, MemWrite, RegWrite and mem_req are forced to 0 while rst_n is low. Reset mid-operation abandons the instruction; no retire.
- Outputs are decoded combinationally from state, plus op, Zero and mem_ready where noted. Any output not listed for a state is 0.
- ImmSrc is decoded from op in every state:
  - lw (0000011) and I-ALU (0010011): 00.
  - sw (0100011): 01.
  - beq (1100011): 10.
  - jal (1101111): 11.
  - all other opcodes: 00.
- PCWrite = PCUpdate | (Branch & Zero).
- States, outputs and transitions:
  - FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite=PCUpdate=mem_ready. Stays in FETCH while mem_ready=0, otherwise goes to DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state by op:
    - lw/sw -> MEMADR
    - R-type (0110011) -> EXECUTER
    - I-ALU -> EXECUTEI
    - jal -> JAL
    - beq -> BEQ
    - other -> FETCH, with illegal set to 1 and no retire.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00. Holds until mem_ready, then goes to MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Goes to FETCH; retire.
  - MEMWRITE: mem_req=1, AdrSrc=1, ResultSrc=00, MemWrite=1; MemWrite stays high until mem_ready. Then goes to FETCH; retire.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Goes to ALUWB.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Goes to ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Goes to FETCH; retire.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Goes to FETCH; retire.
- Latency with mem_ready tied high: lw 5 cycles; sw, R-type, I-ALU and jal 4 cycles; beq 3 cycles. Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Retire means instr_count increments by 1 on the clock edge leaving the final state. It wraps modulo 2^CNT_WIDTH with no saturation.
- illegal stays at 1 until reset. The core keeps running after an illegal opcode.
- op is sampled only in DECODE, MEMADR and ImmSrc decode. The instruction register holds op stable from FETCH completion to the next FETCH.

Test Plan:
- Reset, then lw with mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH; RegWrite=1 only in MEMWB with ResultSrc=01; ImmSrc=00; instr_count=1.
- lw with mem_ready=0 for 3 cycles in MEMREAD -> MEMREAD lasts 4 cycles, mem_req high throughout; total 8 cycles; RegWrite asserted exactly once.
- sw -> ImmSrc=01; MemWrite=1 for exactly 1 cycle (mem_ready=1); RegWrite never asserted; returns to FETCH after 4 cycles.
- beq with Zero=1 -> PCWrite=1 in BEQ, ALUOp=01, ImmSrc=10. Repeat with Zero=0 -> PCWrite=0 in BEQ; both retire (instr_count +1 each).
- op=7'b1111111 -> DECODE then FETCH; illegal=1 and stays 1; instr_count unchanged. Then an R-type instruction -> 4 cycles, ALUOp=10 in EXECUTER, instr_count +1.
- rst_n pulsed low mid-MEMREAD -> state=FETCH and all enables 0 immediately (asynchronous); instr_count=0, illegal=0. Preset instr_count to all-ones, retire one instruction -> instr_count wraps to 0.
